seq_debug_cmd_ctrl: RTL

//  Avalon-MM master that issues one sequencer debug command into the core debug mailbox.
//  - Writes the parameters, then the command word, then polls the status word until the command is done or times out.
//  - Clears the request and returns the final status to the requester.
//  - Sits between the host-side debug/JTAG command path and the sequencer's debug memory region.

---
 rtl/seq_debug_cmd_pkg.sv | 24 ++
 rtl/seq_debug_poll_timer.sv | 46 ++++
 rtl/seq_debug_cmd_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/seq_debug_cmd_pkg.sv
// Shared types and mailbox map for the sequencer debug command controller.
package seq_debug_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_PARAM  = 3'd1,
    WR_CMD    = 3'd2,
    POLL_RD   = 3'd3,
    POLL_WAIT = 3'd4,
    GAP       = 3'd5,
    CLR       = 3'd6,
    RESP      = 3'd7
  } state_t;

  // Core debug mailbox byte addresses
  localparam logic [31:0] REQ_CMD    = 32'h0001_53C8;
  localparam logic [31:0] CMD_STATUS = 32'h0001_53CC;
  localparam logic [31:0] CMD_PARAMS = 32'h0001_53D0;

  // Status word bit positions
  localparam int unsigned STATUS_DONE_BIT = 0;
  localparam int unsigned STATUS_ERR_BIT  = 1;

endpackage

// File: rtl/seq_debug_poll_timer.sv
// Poll pacing: inter-read gap down-counter and saturating poll counter.
module seq_debug_poll_timer #(
  parameter int unsigned POLL_GAP      = 16,
  parameter int unsigned TIMEOUT_POLLS = 1024
) (
  input  logic avl_clk,
  input  logic avl_reset_n,
  input  logic start,
  input  logic tick_read,
  output logic gap_done,
  output logic timed_out
);

  localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_POLLS + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_POLLS);

  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] poll_cnt;

  // Reload the gap on each completed read, then count down to zero and hold.
  always_ff @(posedge avl_clk) begin
    if (!avl_reset_n) begin
      gap_cnt <= '0;
    end else if (tick_read) begin
      gap_cnt <= GAP_LOAD;
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  // Count completed reads since start; saturate at the timeout limit.
  always_ff @(posedge avl_clk) begin
    if (!avl_reset_n || start) begin
      poll_cnt <= '0;
    end else if (tick_read && (poll_cnt != CNT_MAX)) begin
      poll_cnt <= poll_cnt + CNT_W'(1);
    end
  end

  assign gap_done  = (gap_cnt == '0);
  // Qualified by tick_read: true when the read now completing is the last allowed one.
  assign timed_out = tick_read && (poll_cnt >= (CNT_MAX - CNT_W'(1)));

endmodule

// File: rtl/seq_debug_cmd_ctrl.sv
// Avalon-MM master issuing one sequencer debug command into the core mailbox.
module seq_debug_cmd_ctrl
  import seq_debug_cmd_pkg::*;
#(
  parameter int unsigned AVL_ADDR_WIDTH = 32,
  parameter int unsigned AVL_DATA_WIDTH = 32,
  parameter int unsigned NUM_PARAMS     = 4,
  parameter int unsigned POLL_GAP       = 16,
  parameter int unsigned TIMEOUT_POLLS  = 1024,
  localparam int unsigned NP_W          = $clog2(NUM_PARAMS + 1)
) (
  input  logic                               avl_clk,
  input  logic                               avl_reset_n,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [AVL_DATA_WIDTH-1:0]          cmd_id,
  input  logic [NP_W-1:0]                    cmd_nparams,
  input  logic [NUM_PARAMS*AVL_DATA_WIDTH-1:0] cmd_params,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [AVL_DATA_WIDTH-1:0]          rsp_status,
  output logic                               rsp_timeout,
  output logic [AVL_ADDR_WIDTH-1:0]          m_address,
  output logic                               m_read,
  output logic                               m_write,
  output logic [AVL_DATA_WIDTH-1:0]          m_writedata,
  input  logic                               m_waitrequest,
  input  logic [AVL_DATA_WIDTH-1:0]          m_readdata,
  input  logic                               m_readdatavalid
);

  localparam int unsigned IDX_W = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
  localparam logic [NP_W-1:0] NP_MAX = NP_W'(NUM_PARAMS);

  state_t                    state_q, state_d;
  logic [AVL_DATA_WIDTH-1:0] id_q;
  logic [AVL_DATA_WIDTH-1:0] param_mem [NUM_PARAMS];
  logic [NP_W-1:0]           cnt_q;
  logic [IDX_W-1:0]          idx_q;
  logic [NP_W-1:0]           np_clamped;
  logic                      last_param;
  logic [31:0]               param_addr;
  logic                      timer_start;
  logic                      tick_read;
  logic                      gap_done;
  logic                      timed_out;

  assign np_clamped  = (cmd_nparams > NP_MAX) ? NP_MAX : cmd_nparams;
  assign last_param  = (NP_W'(idx_q) == (cnt_q - NP_W'(1)));
  assign param_addr  = CMD_PARAMS + (32'(idx_q) << 2);
  assign timer_start = (state_q == WR_CMD) && !m_waitrequest;
  assign tick_read   = (state_q == POLL_WAIT) && m_readdatavalid;

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  seq_debug_poll_timer #(
    .POLL_GAP      (POLL_GAP),
    .TIMEOUT_POLLS (TIMEOUT_POLLS)
  ) u_poll_timer (
    .avl_clk     (avl_clk),
    .avl_reset_n (avl_reset_n),
    .start       (timer_start),
    .tick_read   (tick_read),
    .gap_done    (gap_done),
    .timed_out   (timed_out)
  );

  // State register.
  always_ff @(posedge avl_clk) begin
    if (!avl_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Avalon strobes; strobes depend only on state so they hold through stalls.
  always_comb begin
    state_d     = state_q;
    m_address   = '0;
    m_read      = 1'b0;
    m_write     = 1'b0;
    m_writedata = '0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = (np_clamped == '0) ? WR_CMD : WR_PARAM;
        end
      end
      WR_PARAM: begin
        m_write     = 1'b1;
        m_address   = AVL_ADDR_WIDTH'(param_addr);
        m_writedata = param_mem[idx_q];
        if (!m_waitrequest && last_param) begin
          state_d = WR_CMD;
        end
      end
      WR_CMD: begin
        m_write     = 1'b1;
        m_address   = AVL_ADDR_WIDTH'(REQ_CMD);
        m_writedata = id_q;
        if (!m_waitrequest) begin
          state_d = POLL_RD;
        end
      end
      POLL_RD: begin
        m_read    = 1'b1;
        m_address = AVL_ADDR_WIDTH'(CMD_STATUS);
        if (!m_waitrequest) begin
          state_d = POLL_WAIT;
        end
      end
      POLL_WAIT: begin
        if (m_readdatavalid) begin
          if (m_readdata[STATUS_DONE_BIT] || timed_out) begin
            state_d = CLR;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_done) begin
          state_d = POLL_RD;
        end
      end
      CLR: begin
        m_write   = 1'b1;
        m_address = AVL_ADDR_WIDTH'(REQ_CMD);
        if (!m_waitrequest) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command capture, param index, and response latching.
  always_ff @(posedge avl_clk) begin
    if (!avl_reset_n) begin
      id_q        <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      rsp_status  <= '0;
      rsp_timeout <= 1'b0;
      for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
        param_mem[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            id_q  <= cmd_id;
            cnt_q <= np_clamped;
            idx_q <= '0;
            for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
              param_mem[i] <= cmd_params[i*AVL_DATA_WIDTH +: AVL_DATA_WIDTH];
            end
          end
        end
        WR_PARAM: begin
          if (!m_waitrequest) begin
            idx_q <= last_param ? '0 : idx_q + IDX_W'(1);
          end
        end
        POLL_WAIT: begin
          if (m_readdatavalid) begin
            rsp_status  <= m_readdata;
            // DONE takes priority over a coincident timeout.
            rsp_timeout <= !m_readdata[STATUS_DONE_BIT] && timed_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
